// File: rtl/rr_arbiter4.sv
// Four-input arbiter with round-robin or fixed-priority selection and a
// bounded hold time per grant. All outputs are registered.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       mode,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  state_t     r_state;
  logic [3:0] r_gnt;
  logic [1:0] r_gnt_id;
  logic       r_gnt_valid;
  logic [1:0] r_last;
  logic [7:0] r_hold;

  state_t     w_state_nxt;
  logic [3:0] w_gnt_nxt;
  logic [1:0] w_gnt_id_nxt;
  logic       w_gnt_valid_nxt;
  logic [1:0] w_last_nxt;
  logic [7:0] w_hold_nxt;
  logic       w_arb;
  logic [3:0] w_elig;
  logic [1:0] w_winner;
  logic       w_forced;

  function automatic logic [1:0] f_fixed_pick(input logic [3:0] elig);
    if (elig[3]) begin
      f_fixed_pick = 2'd3;
    end else if (elig[2]) begin
      f_fixed_pick = 2'd2;
    end else if (elig[1]) begin
      f_fixed_pick = 2'd1;
    end else begin
      f_fixed_pick = 2'd0;
    end
  endfunction

  // Search starts just after the previous winner and wraps 3 -> 0.
  function automatic logic [1:0] f_rr_pick(input logic [3:0] elig, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    f_rr_pick = 2'd0;
    found     = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (elig[idx] && !found) begin
        f_rr_pick = idx;
        found     = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

  // Arbitration decision and next-state/output computation.
  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_gnt_id_nxt    = r_gnt_id;
    w_gnt_valid_nxt = r_gnt_valid;
    w_last_nxt      = r_last;
    w_hold_nxt      = r_hold;
    w_forced        = (r_hold >= HOLD_MAX) && (|(req & ~r_gnt));

    case (r_state)
      ST_IDLE: begin
        w_arb  = 1'b1;
        w_elig = req;
      end
      ST_GRANT: begin
        w_arb  = !req[r_gnt_id] || w_forced;
        w_elig = req & ~r_gnt;
      end
      default: begin
        w_arb  = 1'b1;
        w_elig = 4'b0000;
      end
    endcase

    w_winner = mode ? f_fixed_pick(w_elig) : f_rr_pick(w_elig, r_last);

    if (w_arb) begin
      if (|w_elig) begin
        w_state_nxt     = ST_GRANT;
        w_gnt_nxt       = 4'b0001 << w_winner;
        w_gnt_id_nxt    = w_winner;
        w_gnt_valid_nxt = 1'b1;
        w_last_nxt      = w_winner;
        w_hold_nxt      = 8'd1;
      end else begin
        w_state_nxt     = ST_IDLE;
        w_gnt_nxt       = 4'b0000;
        w_gnt_id_nxt    = 2'd0;
        w_gnt_valid_nxt = 1'b0;
        w_hold_nxt      = 8'd0;
      end
    end else begin
      // Holder keeps the grant; counter saturates rather than wrapping.
      w_hold_nxt = (r_hold >= HOLD_MAX) ? HOLD_MAX : r_hold + 8'd1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gnt       <= 4'b0000;
      r_gnt_id    <= 2'd0;
      r_gnt_valid <= 1'b0;
      r_last      <= 2'd3;
      r_hold      <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_last      <= w_last_nxt;
      r_hold      <= w_hold_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter MAX_HOLD, default 8, is the maximum consecutive grant cycles while another requester waits; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  request per requester, bit i = requester i, level-sensitive.
REQ-005 mode  input  1  0 = round-robin, 1 = fixed priority (req[3] highest, req[0] lowest).
REQ-006 gnt  output  4  one-hot grant, registered.
REQ-007 gnt_id  output  2  binary index of granted requester, registered; 0 when gnt_valid=0.
REQ-008 gnt_valid  output  1  high when any gnt bit is high.

Function
REQ-009 States: IDLE (no grant) and GRANT (one holder); state, gnt, gnt_id, gnt_valid, last pointer and hold counter are all registers.
REQ-010 gnt SHALL be zero or one-hot in every cycle; gnt_valid SHALL equal OR of gnt; gnt_id SHALL encode the set gnt bit.
REQ-011 Arbitration point: any cycle in IDLE, or any GRANT cycle in which the holder is released (REQ-014, REQ-015).
REQ-012 At an arbitration point, if any eligible req bit is high, the winner's gnt bit SHALL be high at the next rising edge (1-cycle latency); otherwise the next state is IDLE with all outputs 0.
REQ-013 Winner selection: mode=1 -> highest-index eligible req; mode=0 -> first eligible req searched from index (last+1) mod 4 upward with wrap 3->0; mode is sampled only at arbitration points.
REQ-014 Voluntary release: holder's req low in a GRANT cycle -> holder excluded from eligibility; remaining requests arbitrate in that same cycle, so back-to-back grants have no idle cycle.
REQ-015 Forced release: hold counter counts grant cycles of the current holder, starting at 1 on the first granted cycle; when the counter equals MAX_HOLD and any other req bit is high, the holder is excluded and the others arbitrate in that cycle.
REQ-016 At MAX_HOLD with no other requester, the holder keeps the grant and the counter saturates at MAX_HOLD (no wrap).
REQ-017 While the holder's req stays high and REQ-015 does not fire, gnt SHALL remain unchanged regardless of other req bits or mode changes.
REQ-018 last SHALL update to the winner's index on every new grant, including grants in fixed mode; the hold counter resets to 1 on each new grant.
REQ-019 A forced-released requester whose req stays high is eligible again at the following arbitration point under normal rules.
REQ-020 req changes on non-holder bits during GRANT have no effect until the next arbitration point.

Reset
REQ-021 rst_n low SHALL immediately, asynchronously, force state=IDLE, gnt=0000, gnt_id=00, gnt_valid=0, hold counter=0 and last=3 (first round-robin search starts at requester 0).
REQ-022 Reset asserted mid-grant SHALL drop the grant with no completion cycle; after rst_n rises, the first grant appears one edge after the first edge that samples req nonzero.

Verification
REQ-023 Reset, req=0101, mode=0 -> next edge gnt=0001, gnt_id=00; req drops bit0 (req=0100) -> next edge gnt=0100, gnt_id=10, no idle cycle.
REQ-024 mode=0, req=1111 held constant, MAX_HOLD=2 -> grants rotate 0001,0001,0010,0010,0100,0100,1000,1000,0001; each holder is held exactly 2 cycles.
REQ-025 mode=1, req=1001 after reset -> gnt=1000, gnt_id=11; holder releases (req=0001) -> gnt=0001; req=0000 -> IDLE, outputs 0.
REQ-026 Single requester req=0010 held 20 cycles, MAX_HOLD=8 -> gnt=0010 continuously; counter stays at 8; no glitch.
REQ-027 rst_n pulsed low during gnt=0100 -> outputs 0 before the next edge; after release with req=0100 -> gnt=0100 one edge later and last restarts from 3.
REQ-028 Random req/mode for 10000 cycles, scoreboard checks REQ-010, the 1-cycle latency and that no waiting requester waits more than 3*MAX_HOLD+3 cycles in mode=0.
